bit_deserialize: RTL and testbench

BIT_DESERIALIZE -- requirements
Module: bit_deserialize

---
 rtl/bit_deserialize.sv | 137 +++++++++++++
 tb/tb_bit_deserialize.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserialize.sv
// bit_deserialize
//   Assembles a qualified serial bit stream into DATA_WIDTH-bit words and hands
//   each completed word to a consumer through a valid/ready output register.
//   A sync marker (qualified by bit_valid) realigns the word boundary. The
//   serial side never stalls: a word completing while the previous word is
//   still unaccepted is dropped and recorded in the sticky overrun flag.
//
//   BLOCK_NAME, X, Y, DX and DY are diagram metadata only. Only the BEHAVIORAL
//   architecture carries logic; the device-specific variants tie outputs low.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bit_in       serial data, sampled when bit_valid=1
//   bit_valid    qualifies bit_in and sync
//   sync         frame-start marker; the qualified bit becomes bit 0 of a word
//   data_out     assembled word, valid while data_valid=1
//   data_valid   output word valid
//   data_ready   consumer accept
//   overrun      sticky flag, set when a completed word is dropped
//   overrun_clr  clears overrun (a coincident new overrun wins)
//
// States
//   state | meaning
//   HUNT  | waiting for sync, incoming bits ignored
//   SHIFT | accumulating bits into the current word
module bit_deserialize #(
    parameter string BLOCK_NAME      = "bit_deserialize",
    parameter int    X               = 0,
    parameter int    Y               = 0,
    parameter int    DX              = 0,
    parameter int    DY              = 0,
    parameter string ARCHITECTURE    = "BEHAVIORAL",
    parameter int    DATA_WIDTH      = 8,
    parameter int    SHIFT_DIRECTION = 1,
    parameter int    REQUIRE_SYNC    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  sync,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    generate
        if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
            typedef enum logic {
                HUNT  = 1'b0,
                SHIFT = 1'b1
            } state_t;

            localparam state_t          RST_STATE = (REQUIRE_SYNC != 0) ? HUNT : SHIFT;
            localparam logic [CW-1:0]   LAST      = CW'(DATA_WIDTH - 1);

            state_t                  state;
            logic [CW-1:0]           cnt;
            logic [DATA_WIDTH-1:0]   sr;
            logic [DATA_WIDTH-1:0]   sr_shifted;
            logic [DATA_WIDTH-1:0]   sr_first;
            logic                    realign;
            logic                    shifting;
            logic                    word_done;
            logic                    drop_word;

            // LSB-first enters at the MSB and moves right so the first bit
            // lands in bit 0; MSB-first enters at the LSB and moves left.
            assign sr_shifted = (SHIFT_DIRECTION != 0) ? {bit_in, sr[DATA_WIDTH-1:1]}
                                                       : {sr[DATA_WIDTH-2:0], bit_in};
            assign sr_first   = (SHIFT_DIRECTION != 0) ? {bit_in, {(DATA_WIDTH-1){1'b0}}}
                                                       : {{(DATA_WIDTH-1){1'b0}}, bit_in};

            assign realign   = bit_valid & sync;
            assign shifting  = (state == SHIFT) & bit_valid & ~sync;
            assign word_done = shifting & (cnt == LAST);
            // The held word has priority; a new word only replaces it on a transfer.
            assign drop_word = word_done & data_valid & ~data_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state      <= RST_STATE;
                    cnt        <= '0;
                    sr         <= '0;
                    data_out   <= '0;
                    data_valid <= 1'b0;
                    overrun    <= 1'b0;
                end else begin
                    case (state)
                        HUNT: begin
                            if (realign) begin
                                state <= SHIFT;
                                sr    <= sr_first;
                                cnt   <= CW'(1);
                            end
                        end
                        SHIFT: begin
                            if (realign) begin
                                sr  <= sr_first;
                                cnt <= CW'(1);
                            end else if (shifting) begin
                                sr  <= sr_shifted;
                                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                            end
                        end
                        default: begin
                            state <= RST_STATE;
                        end
                    endcase

                    if (word_done && (!data_valid || data_ready)) begin
                        data_out   <= sr_shifted;
                        data_valid <= 1'b1;
                    end else if (data_valid && data_ready) begin
                        data_valid <= 1'b0;
                    end

                    if (drop_word) begin
                        overrun <= 1'b1;
                    end else if (overrun_clr) begin
                        overrun <= 1'b0;
                    end
                end
            end
        end else begin : g_stub
            assign data_out   = '0;
            assign data_valid = 1'b0;
            assign overrun    = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bit_deserialize.sv
// Self-checking bench for bit_deserialize (DATA_WIDTH=8).
// Three instances share one stimulus stream:
//   dut 0: MSB-first, sync required
//   dut 1: LSB-first, sync required
//   dut 2: MSB-first, free-running from reset
module tb_bit_deserialize;

    localparam int W = 8;
    localparam int N = 3;

    logic         clk;
    logic         rst_n;
    logic         bit_in;
    logic         bit_valid;
    logic         sync;
    logic         data_ready;
    logic         overrun_clr;
    logic [W-1:0] dout [N];
    logic         dv   [N];
    logic         ov   [N];

    bit_deserialize #(.DATA_WIDTH(W), .SHIFT_DIRECTION(0), .REQUIRE_SYNC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
        .data_out(dout[0]), .data_valid(dv[0]), .data_ready(data_ready),
        .overrun(ov[0]), .overrun_clr(overrun_clr));

    bit_deserialize #(.DATA_WIDTH(W), .SHIFT_DIRECTION(1), .REQUIRE_SYNC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
        .data_out(dout[1]), .data_valid(dv[1]), .data_ready(data_ready),
        .overrun(ov[1]), .overrun_clr(overrun_clr));

    bit_deserialize #(.DATA_WIDTH(W), .SHIFT_DIRECTION(0), .REQUIRE_SYNC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
        .data_out(dout[2]), .data_valid(dv[2]), .data_ready(data_ready),
        .overrun(ov[2]), .overrun_clr(overrun_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic bit lsb_first(input int k);
        return (k == 1);
    endfunction

    function automatic bit needs_sync(input int k);
        return (k != 2);
    endfunction

    // Reference model: keeps the bits of the current word as a list and forms
    // the word arithmetically once the list is full.
    bit           m_aligned [N];
    int           m_n       [N];
    bit           m_bits    [N][W];
    logic [W-1:0] m_dout    [N];
    bit           m_dv      [N];
    bit           m_ov      [N];

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_aligned[k] = !needs_sync(k);
            m_n[k]       = 0;
            m_dout[k]    = '0;
            m_dv[k]      = 1'b0;
            m_ov[k]      = 1'b0;
        end
    endfunction

    function automatic void model_step(input int k);
        bit           done;
        bit           drop;
        int unsigned  word;
        done = 1'b0;
        drop = 1'b0;
        word = 0;
        if (bit_valid) begin
            if (sync) begin
                m_aligned[k] = 1'b1;
                m_bits[k][0] = bit_in;
                m_n[k]       = 1;
            end else if (m_aligned[k]) begin
                m_bits[k][m_n[k]] = bit_in;
                m_n[k]++;
                if (m_n[k] == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++)
                        if (m_bits[k][i])
                            word += lsb_first(k) ? (1 << i) : (1 << (W - 1 - i));
                    m_n[k] = 0;
                end
            end
        end
        if (done) begin
            if (!m_dv[k] || data_ready) begin
                m_dout[k] = word[W-1:0];
                m_dv[k]   = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (m_dv[k] && data_ready) begin
            m_dv[k] = 1'b0;
        end
        if (drop) m_ov[k] = 1'b1;
        else if (overrun_clr) m_ov[k] = 1'b0;
    endfunction

    function automatic void compare_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("dut%0d data_out", k), 64'(dout[k]), 64'(m_dout[k]));
            chk($sformatf("dut%0d data_valid", k), 64'(dv[k]), 64'(m_dv[k]));
            chk($sformatf("dut%0d overrun", k), 64'(ov[k]), 64'(m_ov[k]));
        end
    endfunction

    int words0;

    task automatic tick();
        for (int k = 0; k < N; k++) model_step(k);
        @(posedge clk);
        #1;
        compare_all();
        if (dv[0] === 1'b1 && data_ready) words0++;
    endtask

    task automatic set_in(input bit bv, input bit sy, input bit b);
        bit_valid = bv;
        sync      = sy;
        bit_in    = b;
    endtask

    task automatic idle(input int cycles);
        set_in(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic send_msb(input logic [W-1:0] v, input bit with_sync);
        for (int i = W - 1; i >= 0; i--) begin
            set_in(1'b1, with_sync && (i == W - 1), v[i]);
            tick();
        end
    endtask

    typedef struct {
        bit           bv;
        bit           sy;
        bit           b;
        bit           dv_exp;
        logic [W-1:0] d0_exp;
        logic [W-1:0] d1_exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hC0, 8'h03};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC0, 8'h03};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC0, 8'h03};

        rst_n       = 1'b0;
        data_ready  = 1'b1;
        overrun_clr = 1'b0;
        words0      = 0;
        set_in(1'b0, 1'b0, 1'b0);
        model_reset();
        #23;
        compare_all();
        rst_n = 1'b1;
        #4;

        // Basic word in both bit orders.
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].bv, tbl[i].sy, tbl[i].b);
            tick();
            chk($sformatf("table[%0d] dut0 valid", i), 64'(dv[0]), 64'(tbl[i].dv_exp));
            chk($sformatf("table[%0d] dut1 valid", i), 64'(dv[1]), 64'(tbl[i].dv_exp));
            chk($sformatf("table[%0d] dut0 data", i), 64'(dout[0]), 64'(tbl[i].d0_exp));
            chk($sformatf("table[%0d] dut1 data", i), 64'(dout[1]), 64'(tbl[i].d1_exp));
        end

        // Fresh reset so the unsynced bits below are truly pre-sync for dut0.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        idle(1);
        words0 = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 1'(i & 1));
            tick();
        end
        send_msb(8'hA5, 1'b1);
        idle(2);
        chk("pre-sync word count", 64'(words0), 64'd1);
        chk("pre-sync word value", 64'(dout[0]), 64'hA5);

        // Mid-word realignment.
        words0 = 0;
        set_in(1'b1, 1'b1, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b1); tick();
        set_in(1'b1, 1'b0, 1'b1); tick();
        send_msb(8'h5A, 1'b1);
        idle(2);
        chk("realign word count", 64'(words0), 64'd1);
        chk("realign word value", 64'(dout[0]), 64'h5A);

        // Overrun: hold first word, drop second, then transfer with clear.
        data_ready = 1'b0;
        send_msb(8'h11, 1'b1);
        chk("overrun first valid", 64'(dv[0]), 64'd1);
        send_msb(8'h22, 1'b1);
        idle(1);
        chk("overrun held data", 64'(dout[0]), 64'h11);
        chk("overrun flag set", 64'(ov[0]), 64'd1);
        data_ready  = 1'b1;
        overrun_clr = 1'b1;
        chk("overrun transfer data", 64'(dout[0]), 64'h11);
        tick();
        overrun_clr = 1'b0;
        chk("overrun after transfer valid", 64'(dv[0]), 64'd0);
        chk("overrun after clear", 64'(ov[0]), 64'd0);

        // Async reset partway through a word, between clock edges.
        data_ready = 1'b0;
        send_msb(8'h77, 1'b1);
        data_ready = 1'b1;
        set_in(1'b1, 1'b1, 1'b1); tick();
        set_in(1'b1, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b1); tick();
        set_in(1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("async reset dut%0d data_out", k), 64'(dout[k]), 64'd0);
            chk($sformatf("async reset dut%0d data_valid", k), 64'(dv[k]), 64'd0);
            chk($sformatf("async reset dut%0d overrun", k), 64'(ov[k]), 64'd0);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        words0 = 0;
        send_msb(8'h3C, 1'b1);
        chk("post-reset word value", 64'(dout[0]), 64'h3C);
        idle(1);
        chk("post-reset word count", 64'(words0), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 23) == 0), 1'($urandom));
            data_ready  = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
